io_uart: RTL

Memory-mapped UART peripheral that answers the CPU's SYS-instruction IO bus as the responder. It decodes IO read/write strobes and exposes a DATA register backed by TX and RX FIFOs, plus a STATUS register. It serialises and deserialises 8N1 frames on `uart_tx` and `uart_rx`. It sits beside the core on the same clock and gives SYS programs a byte-stream console.

---
 rtl/io_uart.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/io_uart.sv
// rtl/io_uart.sv - IO-bus UART responder: DATA/STATUS registers, TX/RX FIFOs, 8N1 serialiser
module io_uart #(
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_read_enable,
  input  logic        io_write_enable,
  input  logic [15:0] io_address,
  input  logic [15:0] io_write_data,
  output logic [15:0] io_read_data,
  input  logic        uart_rx,
  output logic        uart_tx
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_END   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic w_sel_data, w_sel_stat, w_stat_rd, w_unused;
  assign w_sel_data = (io_address == BASE_ADDR);
  assign w_sel_stat = (io_address == STAT_ADDR);
  assign w_stat_rd  = io_read_enable && w_sel_stat;
  assign w_unused   = ^io_write_data[15:8];

  logic [7:0]  r_tx_mem [FIFO_DEPTH];
  logic [AW:0] r_tx_wp, r_tx_rp;
  logic [7:0]  r_rx_mem [FIFO_DEPTH];
  logic [AW:0] r_rx_wp, r_rx_rp;

  state_t      r_tx_state, r_rx_state;
  logic [15:0] r_tx_cnt, r_rx_cnt;
  logic [2:0]  r_tx_idx, r_rx_idx;
  logic [7:0]  r_tx_shift, r_rx_shift;
  logic        r_uart_tx, r_rx_meta, r_rx_sync, r_ovr, r_fe;
  logic [15:0] r_read_data;

  logic w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_idle;
  logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_done, w_ovr_set, w_fe_set;

  // Extra pointer bit distinguishes full from empty when the index bits match
  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);

  assign w_tx_pop  = !w_tx_empty &&
                     ((r_tx_state == S_IDLE) || (r_tx_state == S_STOP && r_tx_cnt == BIT_END));
  assign w_tx_push = io_write_enable && w_sel_data && (!w_tx_full || w_tx_pop);
  assign w_tx_idle = w_tx_empty && (r_tx_state == S_IDLE);

  assign w_rx_done = (r_rx_state == S_STOP) && (r_rx_cnt == BIT_END);
  assign w_rx_pop  = io_read_enable && w_sel_data && !w_rx_empty;
  assign w_rx_push = w_rx_done && r_rx_sync && (!w_rx_full || w_rx_pop);
  assign w_ovr_set = w_rx_done && r_rx_sync && w_rx_full && !w_rx_pop;
  assign w_fe_set  = w_rx_done && !r_rx_sync;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= io_write_data[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
    end
  end

  // uart_tx changes on the same edge as every state transition, so each bit is exactly one bit period
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_uart_tx  <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          r_uart_tx <= 1'b1;
          if (w_tx_pop) begin
            r_tx_shift <= r_tx_mem[r_tx_rp[AW-1:0]];
            r_tx_cnt   <= '0;
            r_uart_tx  <= 1'b0;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_uart_tx  <= r_tx_shift[0];
            r_tx_state <= S_DATA;
          end else r_tx_cnt <= r_tx_cnt + 16'd1;
        end
        S_DATA: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'd7) begin
              r_uart_tx  <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              r_tx_idx   <= r_tx_idx + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_uart_tx  <= r_tx_shift[1];
            end
          end else r_tx_cnt <= r_tx_cnt + 16'd1;
        end
        S_STOP: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt <= '0;
            if (w_tx_pop) begin
              r_tx_shift <= r_tx_mem[r_tx_rp[AW-1:0]];
              r_uart_tx  <= 1'b0;
              r_tx_state <= S_START;
            end else r_tx_state <= S_IDLE;
          end else r_tx_cnt <= r_tx_cnt + 16'd1;
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= '0;
          if (!r_rx_sync) r_rx_state <= S_START;
        end
        S_START: begin
          // Mid-start-bit recheck rejects glitches shorter than half a bit
          if (r_rx_cnt == HALF_END) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_state <= r_rx_sync ? S_IDLE : S_DATA;
          end else r_rx_cnt <= r_rx_cnt + 16'd1;
        end
        S_DATA: begin
          if (r_rx_cnt == BIT_END) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            if (r_rx_idx == 3'd7) r_rx_state <= S_STOP;
            else r_rx_idx <= r_rx_idx + 3'd1;
          end else r_rx_cnt <= r_rx_cnt + 16'd1;
        end
        S_STOP: begin
          if (r_rx_cnt == BIT_END) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
          end else r_rx_cnt <= r_rx_cnt + 16'd1;
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as the STATUS-read clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovr       <= 1'b0;
      r_fe        <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_ovr <= w_ovr_set || (r_ovr && !w_stat_rd);
      r_fe  <= w_fe_set  || (r_fe  && !w_stat_rd);
      if (io_read_enable && w_sel_data)
        r_read_data <= w_rx_empty ? 16'h0000 : {8'h00, r_rx_mem[r_rx_rp[AW-1:0]]};
      else if (w_stat_rd)
        r_read_data <= {11'd0, r_fe, w_tx_idle, r_ovr, !w_tx_full, !w_rx_empty};
    end
  end

  assign io_read_data = r_read_data;
  assign uart_tx      = r_uart_tx;
endmodule
